// File: rtl/arrow_track_engine_pkg.sv
// rtl/arrow_track_engine_pkg.sv - shared codes, state encoding and track geometry
package arrow_track_engine_pkg;

  localparam int DEFAULT_NUM_SLOTS  = 26;
  localparam int DEFAULT_HIT_SLOT   = 23;
  localparam int DEFAULT_HOLD_TICKS = 8;
  localparam int DEFAULT_SCORE_W    = 16;

  typedef logic [2:0] arrow_code_t;
  typedef logic [1:0] indicator_t;

  localparam arrow_code_t ARROW_NONE  = 3'b000;
  localparam arrow_code_t ARROW_UP    = 3'b001;
  localparam arrow_code_t ARROW_LEFT  = 3'b010;
  localparam arrow_code_t ARROW_DOWN  = 3'b011;
  localparam arrow_code_t ARROW_RIGHT = 3'b100;
  localparam arrow_code_t ARROW_SHAKE = 3'b110;

  localparam indicator_t IND_NONE      = 2'b00;
  localparam indicator_t IND_BAD       = 2'b01;
  localparam indicator_t IND_GOOD      = 2'b10;
  localparam indicator_t IND_EXCELLENT = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/arrow_track_engine_player_judge.sv
// rtl/arrow_track_engine_player_judge.sv - per-player hit mask, judgement, indicator and score
module player_judge
  import arrow_track_engine_pkg::*;
#(
  parameter int NUM_SLOTS  = DEFAULT_NUM_SLOTS,
  parameter int HIT_SLOT   = DEFAULT_HIT_SLOT,
  parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS,
  parameter int SCORE_W    = DEFAULT_SCORE_W
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   active,
  input  logic                   tick,
  input  logic                   shift_en,
  input  logic                   press,
  input  logic [2:0]             code,
  input  logic [3*NUM_SLOTS-1:0] track,
  output logic [1:0]             indicator,
  output logic [SCORE_W-1:0]     score
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  logic [NUM_SLOTS-1:0] hit_mask;
  logic [NUM_SLOTS-1:0] shifted_mask;
  logic [NUM_SLOTS-1:0] set_mask;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 judge;
  logic                 miss;
  logic [1:0]           verdict;
  logic [1:0]           bonus;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_next;

  assign judge = active & press;
  assign miss  = shift_en & (track[3*(NUM_SLOTS-1) +: 3] != ARROW_NONE) & ~hit_mask[NUM_SLOTS-1];

  // Candidates are checked against the pre-shift track; a hit found on a tick
  // cycle is recorded one slot further down so it follows its arrow.
  always_comb begin
    set_mask = '0;
    verdict  = IND_BAD;
    bonus    = 2'd0;
    if (judge && code != ARROW_NONE) begin
      if (track[3*HIT_SLOT +: 3] == code && !hit_mask[HIT_SLOT]) begin
        set_mask[HIT_SLOT] = 1'b1;
        verdict            = IND_EXCELLENT;
        bonus              = 2'd3;
      end else if (track[3*(HIT_SLOT-1) +: 3] == code && !hit_mask[HIT_SLOT-1]) begin
        set_mask[HIT_SLOT-1] = 1'b1;
        verdict              = IND_GOOD;
        bonus                = 2'd1;
      end else if (track[3*(HIT_SLOT+1) +: 3] == code && !hit_mask[HIT_SLOT+1]) begin
        set_mask[HIT_SLOT+1] = 1'b1;
        verdict              = IND_GOOD;
        bonus                = 2'd1;
      end
    end
    shifted_mask = hit_mask;
    if (shift_en) begin
      shifted_mask = {hit_mask[NUM_SLOTS-2:0], 1'b0};
      set_mask     = set_mask << 1;
    end
    score_sum  = {1'b0, score} + {{(SCORE_W-1){1'b0}}, bonus};
    score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_mask  <= '0;
      hold_cnt  <= '0;
      indicator <= IND_NONE;
      score     <= '0;
    end else if (clear) begin
      hit_mask  <= '0;
      hold_cnt  <= '0;
      indicator <= IND_NONE;
      score     <= '0;
    end else begin
      hit_mask <= shifted_mask | set_mask;
      if (judge) begin
        indicator <= verdict;
        hold_cnt  <= HOLD_LOAD;
        score     <= score_next;
      end else if (miss) begin
        indicator <= IND_BAD;
        hold_cnt  <= HOLD_LOAD;
      end else if (tick && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
        if (hold_cnt == HOLD_W'(1)) indicator <= IND_NONE;
      end
    end
  end

endmodule

// File: rtl/arrow_track_engine.sv
// rtl/arrow_track_engine.sv - scrolling arrow track, song FSM and two player judges
module arrow_track_engine
  import arrow_track_engine_pkg::*;
#(
  parameter int NUM_SLOTS  = DEFAULT_NUM_SLOTS,
  parameter int HIT_SLOT   = DEFAULT_HIT_SLOT,
  parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS,
  parameter int SCORE_W    = DEFAULT_SCORE_W
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   tick,
  input  logic                   start,
  input  logic [2:0]             feed_code,
  input  logic                   feed_valid,
  input  logic                   feed_last,
  output logic                   feed_ready,
  input  logic                   p1_press,
  input  logic [2:0]             p1_code,
  input  logic                   p2_press,
  input  logic [2:0]             p2_code,
  output logic [3*NUM_SLOTS-1:0] arrow_array,
  output logic [1:0]             p1_indicator,
  output logic [1:0]             p2_indicator,
  output logic [SCORE_W-1:0]     p1_score,
  output logic [SCORE_W-1:0]     p2_score,
  output logic                   busy
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] drain_cnt;
  logic             active;
  logic             clear;
  logic             shift_en;
  logic             xfer;
  logic [2:0]       insert_code;

  assign active      = (state == ST_RUN) | (state == ST_DRAIN);
  assign clear       = start & ((state == ST_IDLE) | (state == ST_DONE));
  assign shift_en    = tick & active;
  assign feed_ready  = tick & (state == ST_RUN);
  assign xfer        = feed_ready & feed_valid;
  assign insert_code = xfer ? feed_code : ARROW_NONE;
  assign busy        = active;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      drain_cnt   <= '0;
      arrow_array <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state <= ST_RUN;
        ST_RUN: if (xfer && feed_last) begin
          state     <= ST_DRAIN;
          drain_cnt <= CNT_W'(NUM_SLOTS);
        end
        ST_DRAIN: if (tick) begin
          drain_cnt <= drain_cnt - CNT_W'(1);
          if (drain_cnt == CNT_W'(1)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
      if (clear) arrow_array <= '0;
      else if (shift_en) arrow_array <= {arrow_array[3*NUM_SLOTS-4:0], insert_code};
    end
  end

  player_judge #(
    .NUM_SLOTS(NUM_SLOTS), .HIT_SLOT(HIT_SLOT), .HOLD_TICKS(HOLD_TICKS), .SCORE_W(SCORE_W)
  ) u_p1_judge (
    .clock(clock), .resetn(resetn), .clear(clear), .active(active), .tick(tick),
    .shift_en(shift_en), .press(p1_press), .code(p1_code), .track(arrow_array),
    .indicator(p1_indicator), .score(p1_score)
  );

  player_judge #(
    .NUM_SLOTS(NUM_SLOTS), .HIT_SLOT(HIT_SLOT), .HOLD_TICKS(HOLD_TICKS), .SCORE_W(SCORE_W)
  ) u_p2_judge (
    .clock(clock), .resetn(resetn), .clear(clear), .active(active), .tick(tick),
    .shift_en(shift_en), .press(p2_press), .code(p2_code), .track(arrow_array),
    .indicator(p2_indicator), .score(p2_score)
  );

endmodule

// File: tb/tb_arrow_track_engine.sv
// tb/tb_arrow_track_engine.sv - directed self-checking bench for arrow_track_engine
module tb_arrow_track_engine;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  feed_code = 3'b000;
  logic        feed_valid = 1'b0;
  logic        feed_last = 1'b0;
  logic        feed_ready;
  logic        p1_press = 1'b0;
  logic [2:0]  p1_code = 3'b000;
  logic        p2_press = 1'b0;
  logic [2:0]  p2_code = 3'b000;
  logic [77:0] arrow_array;
  logic [1:0]  p1_indicator;
  logic [1:0]  p2_indicator;
  logic [15:0] p1_score;
  logic [15:0] p2_score;
  logic        busy;

  int checks = 0;
  int errors = 0;

  arrow_track_engine dut (
    .clock(clock), .resetn(resetn), .tick(tick), .start(start),
    .feed_code(feed_code), .feed_valid(feed_valid), .feed_last(feed_last),
    .feed_ready(feed_ready), .p1_press(p1_press), .p1_code(p1_code),
    .p2_press(p2_press), .p2_code(p2_code), .arrow_array(arrow_array),
    .p1_indicator(p1_indicator), .p2_indicator(p2_indicator),
    .p1_score(p1_score), .p2_score(p2_score), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_feed(input logic v, input logic [2:0] c, input logic last);
    tick = 1'b1; feed_valid = v; feed_code = c; feed_last = last;
    step();
    tick = 1'b0; feed_valid = 1'b0; feed_code = 3'b000; feed_last = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick_feed(1'b0, 3'b000, 1'b0);
  endtask

  task automatic press(input int who, input logic [2:0] c, input logic with_tick);
    if (who == 1) begin p1_press = 1'b1; p1_code = c; end
    else begin p2_press = 1'b1; p2_code = c; end
    tick = with_tick;
    step();
    p1_press = 1'b0; p2_press = 1'b0; p1_code = 3'b000; p2_code = 3'b000; tick = 1'b0;
  endtask

  task automatic restart();
    resetn = 1'b0; step(); resetn = 1'b1;
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (arrow_array !== 78'd0) begin errors++; $display("FAIL reset_array: got %0h expected 0", arrow_array); end
    checks++; if ({p1_indicator, p2_indicator, p1_score, p2_score} !== 36'd0) begin errors++; $display("FAIL reset_players: got %0h expected 0", {p1_indicator, p2_indicator, p1_score, p2_score}); end
    checks++; if ({busy, feed_ready} !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00", {busy, feed_ready}); end
    resetn = 1'b1; step();
    start = 1'b1; step(); start = 1'b0;
    tick_feed(1'b1, 3'b001, 1'b0);
    tick_feed(1'b1, 3'b100, 1'b0);
    press(1, 3'b000, 1'b0);
    checks++; if (arrow_array !== 78'd12) begin errors++; $display("FAIL pre_reset_array: got %0h expected c", arrow_array); end
    checks++; if (p1_indicator !== 2'b01) begin errors++; $display("FAIL pre_reset_p1_ind: got %b expected 01", p1_indicator); end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({arrow_array, p1_indicator, p2_indicator, busy} !== 83'd0) begin errors++; $display("FAIL async_reset: got %0h expected 0", {arrow_array, p1_indicator, p2_indicator, busy}); end
    step(); resetn = 1'b1;
    tick_feed(1'b1, 3'b001, 1'b0);
    checks++; if ({arrow_array, busy} !== 79'd0) begin errors++; $display("FAIL idle_after_reset: got %0h expected 0", {arrow_array, busy}); end
  endtask

  task automatic test_start_feed();
    start = 1'b1; step(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    checks++; if (feed_ready !== 1'b0) begin errors++; $display("FAIL ready_no_tick: got %b expected 0", feed_ready); end
    tick = 1'b1; feed_valid = 1'b1; feed_code = 3'b001;
    #1;
    checks++; if (feed_ready !== 1'b1) begin errors++; $display("FAIL ready_on_tick: got %b expected 1", feed_ready); end
    step();
    tick = 1'b0; feed_valid = 1'b0; feed_code = 3'b000;
    #1;
    checks++; if (feed_ready !== 1'b0) begin errors++; $display("FAIL ready_after_tick: got %b expected 0", feed_ready); end
    checks++; if (arrow_array[2:0] !== 3'b001) begin errors++; $display("FAIL slot0_insert: got %b expected 001", arrow_array[2:0]); end
  endtask

  task automatic test_scroll_miss();
    restart();
    tick_feed(1'b1, 3'b010, 1'b0);
    idle_ticks(25);
    checks++; if (arrow_array[77:75] !== 3'b010) begin errors++; $display("FAIL slot25_code: got %b expected 010", arrow_array[77:75]); end
    checks++; if ({p1_indicator, p2_indicator} !== 4'b0000) begin errors++; $display("FAIL pre_miss_ind: got %b expected 0000", {p1_indicator, p2_indicator}); end
    idle_ticks(1);
    checks++; if ({p1_indicator, p2_indicator} !== 4'b0101) begin errors++; $display("FAIL miss_ind: got %b expected 0101", {p1_indicator, p2_indicator}); end
    checks++; if (arrow_array !== 78'd0) begin errors++; $display("FAIL track_empty: got %0h expected 0", arrow_array); end
    idle_ticks(7);
    checks++; if ({p1_indicator, p2_indicator} !== 4'b0101) begin errors++; $display("FAIL hold_7: got %b expected 0101", {p1_indicator, p2_indicator}); end
    idle_ticks(1);
    checks++; if ({p1_indicator, p2_indicator} !== 4'b0000) begin errors++; $display("FAIL hold_expire: got %b expected 0000", {p1_indicator, p2_indicator}); end
  endtask

  task automatic test_excellent();
    restart();
    tick_feed(1'b1, 3'b011, 1'b0);
    idle_ticks(23);
    checks++; if (arrow_array[71:69] !== 3'b011) begin errors++; $display("FAIL slot23_code: got %b expected 011", arrow_array[71:69]); end
    press(1, 3'b011, 1'b0);
    checks++; if (p1_indicator !== 2'b11) begin errors++; $display("FAIL excellent_ind: got %b expected 11", p1_indicator); end
    checks++; if (p1_score !== 16'd3) begin errors++; $display("FAIL excellent_score: got %0d expected 3", p1_score); end
    press(1, 3'b011, 1'b0);
    checks++; if (p1_indicator !== 2'b01) begin errors++; $display("FAIL double_ind: got %b expected 01", p1_indicator); end
    checks++; if (p1_score !== 16'd3) begin errors++; $display("FAIL double_score: got %0d expected 3", p1_score); end
    idle_ticks(3);
    checks++; if (p2_indicator !== 2'b01) begin errors++; $display("FAIL p2_exit_miss: got %b expected 01", p2_indicator); end
    idle_ticks(5);
    checks++; if ({p1_indicator, p2_indicator} !== 4'b0001) begin errors++; $display("FAIL p1_no_miss: got %b expected 0001", {p1_indicator, p2_indicator}); end
    checks++; if (p2_score !== 16'd0) begin errors++; $display("FAIL p2_score_zero: got %0d expected 0", p2_score); end
  endtask

  task automatic test_good_priority();
    restart();
    tick_feed(1'b1, 3'b100, 1'b0);
    tick_feed(1'b0, 3'b000, 1'b0);
    tick_feed(1'b1, 3'b100, 1'b0);
    idle_ticks(22);
    checks++; if ({arrow_array[74:72], arrow_array[71:69], arrow_array[68:66]} !== 9'b100_000_100) begin errors++; $display("FAIL slots_24_22: got %b expected 100000100", {arrow_array[74:72], arrow_array[71:69], arrow_array[68:66]}); end
    press(2, 3'b100, 1'b0);
    checks++; if ({p2_indicator, p2_score} !== {2'b10, 16'd1}) begin errors++; $display("FAIL good_first: got %0h expected 20001", {p2_indicator, p2_score}); end
    checks++; if (dut.u_p2_judge.hit_mask[22] !== 1'b1) begin errors++; $display("FAIL hit_bit22: got %b expected 1", dut.u_p2_judge.hit_mask[22]); end
    press(2, 3'b100, 1'b0);
    checks++; if ({p2_indicator, p2_score} !== {2'b10, 16'd2}) begin errors++; $display("FAIL good_second: got %0h expected 20002", {p2_indicator, p2_score}); end
    checks++; if (dut.u_p2_judge.hit_mask[24] !== 1'b1) begin errors++; $display("FAIL hit_bit24: got %b expected 1", dut.u_p2_judge.hit_mask[24]); end
    press(2, 3'b100, 1'b0);
    checks++; if ({p2_indicator, p2_score} !== {2'b01, 16'd2}) begin errors++; $display("FAIL no_candidate: got %0h expected 10002", {p2_indicator, p2_score}); end
    checks++; if (p1_score !== 16'd0) begin errors++; $display("FAIL p1_untouched: got %0d expected 0", p1_score); end
  endtask

  task automatic test_simultaneous();
    restart();
    tick_feed(1'b1, 3'b110, 1'b0);
    idle_ticks(24);
    checks++; if (arrow_array[74:72] !== 3'b110) begin errors++; $display("FAIL slot24_shake: got %b expected 110", arrow_array[74:72]); end
    press(1, 3'b110, 1'b1);
    checks++; if ({p1_indicator, p1_score} !== {2'b10, 16'd1}) begin errors++; $display("FAIL simul_good: got %0h expected 20001", {p1_indicator, p1_score}); end
    checks++; if (arrow_array[77:75] !== 3'b110) begin errors++; $display("FAIL simul_shift: got %b expected 110", arrow_array[77:75]); end
    checks++; if (dut.u_p1_judge.hit_mask[25] !== 1'b1) begin errors++; $display("FAIL hit_bit25: got %b expected 1", dut.u_p1_judge.hit_mask[25]); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if ({busy, p1_score} !== {1'b1, 16'd1}) begin errors++; $display("FAIL start_in_run: got %0h expected 10001", {busy, p1_score}); end
    idle_ticks(1);
    checks++; if ({p1_indicator, p2_indicator} !== 4'b1001) begin errors++; $display("FAIL simul_exit: got %b expected 1001", {p1_indicator, p2_indicator}); end
  endtask

  task automatic test_drain();
    restart();
    tick_feed(1'b1, 3'b001, 1'b0);
    tick_feed(1'b1, 3'b010, 1'b0);
    tick_feed(1'b1, 3'b011, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %b expected 1", busy); end
    tick = 1'b1; feed_valid = 1'b1; feed_code = 3'b100;
    #1;
    checks++; if (feed_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b expected 0", feed_ready); end
    step();
    tick = 1'b0; feed_valid = 1'b0; feed_code = 3'b000;
    idle_ticks(20);
    checks++; if ({arrow_array[71:63], arrow_array[62:0]} !== {9'b001_010_011, 63'd0}) begin errors++; $display("FAIL drain_track: got %0h expected %0h", arrow_array[71:0], {9'b001_010_011, 63'd0}); end
    press(1, 3'b001, 1'b0);
    press(2, 3'b010, 1'b0);
    checks++; if ({p1_score, p2_score} !== {16'd3, 16'd1}) begin errors++; $display("FAIL drain_scores: got %0h expected 30001", {p1_score, p2_score}); end
    idle_ticks(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_25: got %b expected 1", busy); end
    idle_ticks(1);
    checks++; if ({busy, arrow_array} !== 79'd0) begin errors++; $display("FAIL done_state: got %0h expected 0", {busy, arrow_array}); end
    checks++; if ({p1_score, p2_score} !== {16'd3, 16'd1}) begin errors++; $display("FAIL done_scores: got %0h expected 30001", {p1_score, p2_score}); end
    tick_feed(1'b1, 3'b001, 1'b0);
    checks++; if (arrow_array !== 78'd0) begin errors++; $display("FAIL done_no_shift: got %0h expected 0", arrow_array); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if ({busy, p1_score, p2_score} !== {1'b1, 32'd0}) begin errors++; $display("FAIL restart_clear: got %0h expected 100000000", {busy, p1_score, p2_score}); end
  endtask

  initial begin
    test_reset();
    test_start_feed();
    test_scroll_miss();
    test_excellent();
    test_good_priority();
    test_simultaneous();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arrow_track_engine.md
Name: arrow_track_engine

Overview:
- Produces the scrolling arrow state and per-player judgement indicators consumed by the pixel colour-index logic.
- Pulls one arrow code per scroll tick from the song-chart feed and shifts it down a 26-slot track. Slot 0 is at the top; slot 25 is the bottom.
- Judges both players' button presses against the hit zone and maintains saturating scores.
- Sits between the chart ROM/sequencer and the VGA index path.

Parameters:
- NUM_SLOTS, 26, track depth; arrow_array width is 3*NUM_SLOTS.
- HIT_SLOT, 23, slot whose arrow exactly fills the hit block (rows 368-431).
- HOLD_TICKS, 8, ticks an indicator stays non-zero after a judgement.
- SCORE_W, 16, score counter width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle scroll strobe.
- start  in  1  begin or restart a song.
- feed_code  in  3  next arrow code: 000 none, 001 up, 010 left, 011 down, 100 right, 110 shake.
- feed_valid  in  1  feed_code valid.
- feed_last  in  1  qualifies feed_code as the final chart entry.
- feed_ready  out  1  consume strobe to the feed.
- p1_press, p2_press  in  1 each  single-cycle button strobe.
- p1_code, p2_code  in  3 each  lane pressed; same encoding as feed_code.
- arrow_array  out  78  slot i occupies bits [3i+2:3i].
- p1_indicator, p2_indicator  out  2 each  11 excellent, 10 good, 01 bad, 00 none.
- p1_score, p2_score  out  SCORE_W each  running scores.
- busy  out  1  FSM in RUN or DRAIN.

Behaviour:
- Reset: every output is 0, including arrow_array, both hit masks, indicators, scores, hold counters and feed_ready. FSM goes to IDLE. Reset takes effect immediately at any point, including mid-song.
- FSM:
  - IDLE: start -> RUN. Clears the track, hit masks, scores and indicators.
  - RUN: on tick, feed_ready=1 combinationally for that cycle. The data transfer happens when tick & feed_valid.
    - A transfer inserts feed_code at slot 0.
    - tick & !feed_valid inserts 000 (a starved feed is not an error).
    - A transfer with feed_last -> DRAIN; the drain counter loads NUM_SLOTS.
  - DRAIN: feed_ready=0. Each tick inserts 000 and decrements the counter. Counter reaching 0 -> DONE.
  - DONE: track is empty; scores are held. start -> RUN with the same clearing as IDLE->RUN.
  - start in RUN or DRAIN is ignored.
- Shift on tick (RUN/DRAIN only): slot[i] <= slot[i-1] for i=1..25. Each player's 26-bit hit mask shifts in lockstep, with bit 0 <= 0.
- Miss: on a tick, if slot 25 is non-zero and that player's hit bit 25 is 0, that player gets a bad judgement. This applies independently per player.
- Press judgement (RUN/DRAIN only): evaluated against pre-shift contents in the same cycle, so a simultaneous tick uses the old track.
  - Candidates are slots HIT_SLOT, HIT_SLOT-1 and HIT_SLOT+1, in that priority, where slot code equals the pressed code and that player's hit bit is 0.
  - Match at HIT_SLOT -> excellent, score +3.
  - Match at an adjacent slot -> good, score +1.
  - The matched hit bit is set; with a simultaneous tick it is set at the post-shift position.
  - No match, or press code 000 -> bad, score unchanged.
  - Scores saturate at all-ones.
- Indicator: every judgement loads the code and resets the hold counter to HOLD_TICKS. Each tick decrements the counter; at 0 the indicator returns to 00.
- Simultaneous press judgement and miss for the same player in one cycle: the press result wins the indicator; the miss is dropped.
- Presses in IDLE or DONE are ignored.
- Latency: every output is registered and updates on the clock edge following the causing event.

Decomposition:
- Shared package holds:
  - the arrow code constants (NONE, UP, LEFT, DOWN, RIGHT, SHAKE);
  - the indicator code constants (NONE, BAD, GOOD, EXCELLENT);
  - the FSM state encoding;
  - NUM_SLOTS and HIT_SLOT defaults, also used by the index path.
- One sub-module, player_judge, is instantiated twice. It owns the hit mask, the judgement, the indicator hold counter and the score. It takes the track, tick, press, code and the shift enable as inputs.

Test Plan:
- Reset and start:
  - Reset while RUN with non-zero track -> all outputs 0, FSM IDLE.
  - start, then feed 001 on one tick -> arrow_array[2:0]=001, feed_ready high only during the tick cycle.
- Scroll and miss:
  - Feed 010 then 25 ticks with feed_valid=0 -> code 010 sits at slot 25, bits [77:75].
  - One more tick -> p1_indicator=01, p2_indicator=01; after 8 further ticks both return to 00.
- Excellent and double press:
  - Arrow 011 at slot 23, p1_press with code 011 -> p1_indicator=11, p1_score=3.
  - Repeat press with no tick -> p1_indicator=01, p1_score stays 3.
  - When that arrow exits slot 25, P1 gets no miss; P2 does (p2_indicator=01).
- Good and priority:
  - Arrow 100 at slots 22 and 24, p2_press with code 100 -> p2_indicator=10, p2_score=1, slot-22 hit bit set.
  - Press 100 again -> slot 24 matched, p2_score=2.
- Simultaneous tick and press:
  - Arrow 110 at slot 24, tick and p1_press with code 110 in the same cycle -> good.
  - The hit bit lands at slot 25 post-shift; no miss on the next tick.
- Drain:
  - Feed 3 codes, the last with feed_last -> state DRAIN.
  - After 26 more ticks -> DONE, arrow_array=0, busy=0, scores held.
  - start -> scores cleared, busy=1.
